// File: rtl/sm_accumulator.sv
// sm_accumulator: saturating sign-magnitude accumulator that sums TERMS input words per request.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   start               begin a new accumulation (honoured only when idle)
//   in_valid/in_ready   term handshake; in_data is a sign-magnitude term
//   out_valid/out_ready result handshake; out_data is the sign-magnitude sum
//   ovf                 sticky saturation flag, cleared on the next start
//   busy                high while accumulating or holding a result
module sm_accumulator #(
  parameter int size  = 16,
  parameter int TERMS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [size-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [size-1:0] out_data,
  output logic            ovf,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t state;
  logic [7:0] cnt;
  logic [size-2:0] ma, mi, mag;
  logic [size-1:0] sum;
  logic sa, si, same, sat, sgn;
  // out_data doubles as the accumulator register
  always_comb begin
    ma   = out_data[size-2:0];
    sa   = out_data[size-1];
    mi   = in_data[size-2:0];
    si   = in_data[size-1] & |mi;
    same = sa == si;
    sum  = {1'b0, ma} + {1'b0, mi};
    sat  = same && sum[size-1];
    mag  = same ? (sat ? '1 : sum[size-2:0]) : (ma >= mi ? ma - mi : mi - ma);
    // a zero magnitude is always forced positive
    sgn  = (same ? sa : (ma >= mi ? sa : si)) & |mag;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      out_data  <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state    <= ACC;
          cnt      <= '0;
          out_data <= '0;
          ovf      <= 1'b0;
          in_ready <= 1'b1;
          busy     <= 1'b1;
        end
        ACC: if (in_valid) begin
          out_data <= {sgn, mag};
          ovf      <= ovf | sat;
          cnt      <= cnt + 8'd1;
          if (cnt == 8'(TERMS - 1)) begin
            state     <= DONE;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sm_accumulator.sv
// tb_sm_accumulator: directed vectors plus randomized runs against an integer-arithmetic model.
module tb_sm_accumulator;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0, out_ready = 0;
  logic [15:0] in_data = 0;
  logic in_ready, out_valid, ovf, busy;
  logic [15:0] out_data;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  sm_accumulator #(.size(16), .TERMS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ovf(ovf), .busy(busy)
  );
  typedef struct {
    logic [63:0] terms;
    logic [15:0] data;
    logic        ovf;
  } vec_t;
  vec_t vecs[4];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_zero(input string name);
    chk({name, " in_ready"}, 32'(in_ready), 0);
    chk({name, " out_valid"}, 32'(out_valid), 0);
    chk({name, " out_data"}, 32'(out_data), 0);
    chk({name, " ovf"}, 32'(ovf), 0);
    chk({name, " busy"}, 32'(busy), 0);
  endtask
  // start an accumulation and feed four terms (first term in bits 15:0)
  task automatic run(input string name, input logic [63:0] t, input bit gaps);
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 4; i++) begin
      if (gaps)
        while ($urandom_range(0, 2) == 0) begin
          in_valid = 0;
          in_data = 16'($urandom);
          @(negedge clk);
          chk({name, " stall busy"}, 32'(busy), 1);
        end
      in_valid = 1;
      in_data = t[16*i+:16];
      chk({name, " in_ready"}, 32'(in_ready), 1);
      if (i == 3) chk({name, " early out_valid"}, 32'(out_valid), 0);
      @(negedge clk);
    end
    in_valid = 0;
    in_data = 16'($urandom);
  endtask
  task automatic take(input string name, input logic [15:0] d, input logic o);
    chk({name, " out_valid"}, 32'(out_valid), 1);
    chk({name, " in_ready low"}, 32'(in_ready), 0);
    chk({name, " out_data"}, 32'(out_data), 32'(d));
    chk({name, " ovf"}, 32'(ovf), 32'(o));
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk({name, " idle out_valid"}, 32'(out_valid), 0);
    chk({name, " idle busy"}, 32'(busy), 0);
    chk({name, " idle ovf"}, 32'(ovf), 32'(o));
  endtask
  function automatic logic [16:0] model(input logic [63:0] t);
    int s = 0;
    bit o = 0;
    for (int i = 0; i < 4; i++) begin
      int m = int'(t[16*i+:15]);
      s += t[16*i+15] ? -m : m;
      if (s > 32767) begin s = 32767; o = 1; end
      if (s < -32767) begin s = -32767; o = 1; end
    end
    return {o, s < 0 ? {1'b1, 15'(-s)} : {1'b0, 15'(s)}};
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    vecs[0] = '{{16'h0001, 16'h8002, 16'h0005, 16'h0003}, 16'h0007, 1'b0};
    vecs[1] = '{{16'h8000, 16'h0000, 16'h0004, 16'h8010}, 16'h800C, 1'b0};
    vecs[2] = '{{16'h0000, 16'h0001, 16'h7000, 16'h7000}, 16'h7FFF, 1'b1};
    vecs[3] = '{{16'h0000, 16'h8000, 16'h8005, 16'h0005}, 16'h0000, 1'b0};
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1;
    in_valid = 1;
    in_data = 16'h1234;
    repeat (2) @(negedge clk);
    chk("idle in_valid in_ready", 32'(in_ready), 0);
    chk("idle in_valid busy", 32'(busy), 0);
    in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      run($sformatf("vec%0d", i), vecs[i].terms, 0);
      take($sformatf("vec%0d", i), vecs[i].data, vecs[i].ovf);
    end
    run("hold", vecs[2].terms, 1);
    for (int i = 0; i < 3; i++) begin
      start = (i == 1);
      @(negedge clk);
      chk("hold out_valid", 32'(out_valid), 1);
      chk("hold out_data", 32'(out_data), 32'h7FFF);
      chk("hold ovf", 32'(ovf), 1);
    end
    start = 0;
    take("hold", 16'h7FFF, 1'b1);
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    in_valid = 1;
    in_data = 16'h0005;
    @(negedge clk);
    in_data = 16'h0007;
    @(negedge clk);
    in_valid = 0;
    #2 rst_n = 0;
    #1 chk_zero("midreset");
    @(negedge clk);
    rst_n = 1;
    run("after reset", {4{16'h0001}}, 0);
    take("after reset", 16'h0004, 1'b0);
    for (int r = 0; r < 40; r++) begin
      logic [63:0] t;
      logic [16:0] e;
      for (int i = 0; i < 4; i++) begin
        logic [14:0] m;
        m = $urandom_range(0, 1) ? 15'($urandom) : 15'($urandom_range(0, 300));
        t[16*i+:16] = {1'($urandom), m};
      end
      e = model(t);
      run($sformatf("rand%0d", r), t, 1);
      take($sformatf("rand%0d", r), e[15:0], e[16]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
